// File: rtl/simon_host_driver.sv
// Host-side driver for a SIMON block-cipher core: bridges valid/ready host channels for
// key, block and result onto the core's request/load/done/read strobes, with a watchdog.
module simon_host_driver #(
  parameter int N = 32,
  parameter int M = 3,
  parameter int W = 16
) (
  input  logic             clk,
  input  logic             nR,
  input  logic             key_valid,
  input  logic [M*N-1:0]   key_in,
  input  logic             mode_in,
  output logic             key_ready,
  input  logic             in_valid,
  input  logic [2*N-1:0]   in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [2*N-1:0]   out_data,
  input  logic             out_ready,
  output logic             newData,
  output logic             newKey,
  output logic             enc_dec,
  output logic [2*N-1:0]   blockIN,
  output logic [M*N-1:0]   KEY,
  output logic             readData,
  input  logic             loadData,
  input  logic             loadKey,
  input  logic             doneData,
  input  logic [2*N-1:0]   outData,
  output logic             busy,
  output logic             timeout,
  output logic [15:0]      blk_count
);

  typedef enum logic [2:0] {IDLE, KEY_REQ, DATA_REQ, BUSY, ACK} state_t;

  // The counter reads k-1 during the k-th cycle in a state, so expiry fires as cycle 2^W-1 ends.
  localparam logic [W-1:0] WD_LAST = {W{1'b1}} - 1'b1;

  state_t         r_state;
  state_t         w_next;
  logic           w_wdogExpire;
  logic           w_keyFire;
  logic           w_inFire;
  logic           w_outFire;
  logic           w_capture;
  logic           w_watched;
  logic           r_keyLoaded;
  logic           r_encDec;
  logic           r_outValid;
  logic           r_timeout;
  logic [M*N-1:0] r_key;
  logic [2*N-1:0] r_blockIn;
  logic [2*N-1:0] r_outData;
  logic [15:0]    r_blkCount;
  logic [W-1:0]   r_wdog;

  assign w_keyFire = key_valid && key_ready;
  assign w_inFire  = in_valid && in_ready;
  assign w_outFire = r_outValid && out_ready;
  assign w_watched = (r_state == KEY_REQ) || (r_state == DATA_REQ) || (r_state == BUSY);
  // A result may be captured in the same cycle the host drains the previous one.
  assign w_capture = (r_state == BUSY) && doneData && (!r_outValid || out_ready);

  always_ff @(posedge clk) begin
    if (!nR) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    w_wdogExpire = 1'b0;
    case (r_state)
      IDLE:     if (w_keyFire) w_next = KEY_REQ;
                else if (w_inFire) w_next = DATA_REQ;
      KEY_REQ:  if (loadKey) w_next = IDLE;
      DATA_REQ: if (loadData) w_next = BUSY;
      BUSY:     if (w_capture) w_next = ACK;
      ACK:      if (!doneData) w_next = IDLE;
      default:  w_next = IDLE;
    endcase
    if ((w_next == r_state) && w_watched && (r_wdog == WD_LAST)) begin
      w_next       = IDLE;
      w_wdogExpire = 1'b1;
    end
  end

  // in_ready drops while a key is offered so the key handshake always wins.
  always_comb begin
    key_ready = (r_state == IDLE);
    in_ready  = (r_state == IDLE) && r_keyLoaded && !r_outValid && !key_valid;
    busy      = (r_state != IDLE);
    newKey    = (r_state == KEY_REQ);
    newData   = (r_state == DATA_REQ);
    readData  = (r_state == ACK);
  end

  always_ff @(posedge clk) begin
    if (!nR) begin
      r_keyLoaded <= 1'b0;
      r_encDec    <= 1'b0;
      r_key       <= '0;
      r_blockIn   <= '0;
      r_outData   <= '0;
      r_outValid  <= 1'b0;
      r_timeout   <= 1'b0;
      r_blkCount  <= '0;
      r_wdog      <= '0;
    end else begin
      if (w_keyFire) begin
        r_key       <= key_in;
        r_encDec    <= mode_in;
        r_keyLoaded <= 1'b0;
      end else if ((r_state == KEY_REQ) && loadKey) begin
        r_keyLoaded <= 1'b1;
      end
      if (w_inFire) r_blockIn <= in_data;
      if (w_capture) begin
        r_outData  <= outData;
        r_outValid <= 1'b1;
      end else if (w_outFire) begin
        r_outValid <= 1'b0;
      end
      if (w_wdogExpire) r_timeout <= 1'b1;
      if ((r_state == ACK) && !doneData) r_blkCount <= r_blkCount + 16'd1;
      if (w_next != r_state) r_wdog <= '0;
      else if (w_watched)    r_wdog <= r_wdog + 1'b1;
    end
  end

  assign out_valid = r_outValid;
  assign out_data  = r_outData;
  assign enc_dec   = r_encDec;
  assign blockIN   = r_blockIn;
  assign KEY       = r_key;
  assign timeout   = r_timeout;
  assign blk_count = r_blkCount;

endmodule

// File: tb/tb_simon_host_driver.sv
// Bench for simon_host_driver: a scripted stand-in for the cipher core plus a host-side
// queue of expected results; watchdog width is shrunk to 4 so expiry is quick to reach.
module tb_simon_host_driver;

  localparam int N = 32;
  localparam int M = 3;
  localparam int W = 4;
  localparam logic [95:0] KEY_V = 96'h13121110_0B0A0908_03020100;
  localparam logic [63:0] PT    = 64'h6F7220676E696C63;
  localparam logic [63:0] CT    = 64'h5CA2E27F111A8FC8;

  logic          clk;
  logic          nR;
  logic          key_valid;
  logic [95:0]   key_in;
  logic          mode_in;
  logic          key_ready;
  logic          in_valid;
  logic [63:0]   in_data;
  logic          in_ready;
  logic          out_valid;
  logic [63:0]   out_data;
  logic          out_ready;
  logic          newData;
  logic          newKey;
  logic          enc_dec;
  logic [63:0]   blockIN;
  logic [95:0]   KEY;
  logic          readData;
  logic          loadData;
  logic          loadKey;
  logic          doneData;
  logic [63:0]   outData;
  logic          busy;
  logic          timeout;
  logic [15:0]   blk_count;

  int            assertCount = 0;
  int            failCount = 0;
  logic [63:0]   expQ[$];
  int            blkExp;
  logic [95:0]   curKey;
  logic          curMode;
  int            coreLatency;
  int            coreHold;
  bit            coreStall;

  simon_host_driver #(.N(N), .M(M), .W(W)) dut (
    .clk(clk), .nR(nR), .key_valid(key_valid), .key_in(key_in), .mode_in(mode_in),
    .key_ready(key_ready), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready), .newData(newData),
    .newKey(newKey), .enc_dec(enc_dec), .blockIN(blockIN), .KEY(KEY), .readData(readData),
    .loadData(loadData), .loadKey(loadKey), .doneData(doneData), .outData(outData),
    .busy(busy), .timeout(timeout), .blk_count(blk_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Core stand-in: reproduces the published SIMON64/96 vectors, otherwise an invertible mix.
  function automatic logic [63:0] coreFn(input logic [63:0] blk, input logic [95:0] k, input logic m);
    if (k == KEY_V && m && blk == PT) return CT;
    if (k == KEY_V && !m && blk == CT) return PT;
    return m ? ((blk ^ k[63:0]) + 64'd1) : ((blk - 64'd1) ^ k[63:0]);
  endfunction

  initial begin : core
    int phase;
    int cnt;
    int hold;
    logic [63:0] capBlk;
    logic [95:0] capKey;
    logic        capMode;
    loadKey = 0; loadData = 0; doneData = 0; outData = '0;
    phase = 0; cnt = 0; hold = 0; capBlk = '0; capKey = '0; capMode = 0;
    forever begin
      @(posedge clk); #2;
      if (!nR) begin
        loadKey = 0; loadData = 0; doneData = 0; phase = 0;
      end else begin
        loadKey = newKey;
        case (phase)
          0: if (newData && !coreStall) begin
               loadData = 1; capBlk = blockIN; capKey = KEY; capMode = enc_dec;
               cnt = coreLatency; phase = 1;
             end
          1: begin
               loadData = 0;
               if (cnt == 0) begin
                 doneData = 1; outData = coreFn(capBlk, capKey, capMode); hold = coreHold; phase = 2;
               end else cnt--;
             end
          default: if (readData) begin
               if (hold == 0) begin doneData = 0; phase = 0; end
               else hold--;
             end
        endcase
      end
    end
  end

  task automatic checkBit(input string tag, input logic obs, input logic exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic checkWord(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkZeroOutputs(input string tag);
    checkBit({tag, "_busy"}, busy, 1'b0);
    checkBit({tag, "_newKey"}, newKey, 1'b0);
    checkBit({tag, "_newData"}, newData, 1'b0);
    checkBit({tag, "_readData"}, readData, 1'b0);
    checkBit({tag, "_enc_dec"}, enc_dec, 1'b0);
    checkBit({tag, "_out_valid"}, out_valid, 1'b0);
    checkBit({tag, "_timeout"}, timeout, 1'b0);
    checkWord({tag, "_blk_count"}, 128'(blk_count), 128'(0));
    checkWord({tag, "_KEY"}, 128'(KEY), 128'(0));
    checkWord({tag, "_blockIN"}, 128'(blockIN), 128'(0));
    checkWord({tag, "_out_data"}, 128'(out_data), 128'(0));
    checkBit({tag, "_key_ready"}, key_ready, 1'b1);
    checkBit({tag, "_in_ready"}, in_ready, 1'b0);
  endtask

  task automatic waitIdle(input string tag);
    int c = 0;
    while (busy !== 1'b0 && c < 100) begin @(negedge clk); c++; end
    checkBit(tag, busy, 1'b0);
  endtask

  task automatic waitOutValid(input string tag);
    int c = 0;
    while (out_valid !== 1'b1 && c < 100) begin @(negedge clk); c++; end
    checkBit(tag, out_valid, 1'b1);
  endtask

  task automatic applyKey(input logic [95:0] k, input logic m);
    int c = 0;
    key_in = k; mode_in = m; key_valid = 1;
    while (key_ready !== 1'b1 && c < 100) begin @(negedge clk); c++; end
    checkBit("key_ready_wait", key_ready, 1'b1);
    @(negedge clk);
    key_valid = 0; curKey = k; curMode = m;
  endtask

  task automatic applyBlock(input logic [63:0] blk, input bit wantResult);
    int c = 0;
    in_data = blk; in_valid = 1;
    while (in_ready !== 1'b1 && c < 100) begin @(negedge clk); c++; end
    checkBit("in_ready_wait", in_ready, 1'b1);
    @(negedge clk);
    in_valid = 0;
    if (wantResult) expQ.push_back(coreFn(blk, curKey, curMode));
  endtask

  task automatic drainResult(input string tag, input int holdCycles);
    waitOutValid({tag, "_wait"});
    blkExp++;
    repeat (holdCycles) begin
      @(negedge clk);
      checkBit({tag, "_hold_in_ready"}, in_ready, 1'b0);
      checkBit({tag, "_hold_out_valid"}, out_valid, 1'b1);
    end
    out_ready = 1;
    checkBit({tag, "_queued"}, expQ.size() != 0, 1'b1);
    if (expQ.size() != 0) checkWord({tag, "_out_data"}, 128'(out_data), 128'(expQ.pop_front()));
    @(negedge clk);
    out_ready = 0;
  endtask

  initial begin : global_bound
    #200000;
    $display("[TB] FAIL global_timeout observed=running expected=finished");
    $fatal(1, "[TB] simulation time bound exceeded");
  end

  initial begin : main
    int c;
    logic [63:0] nextBlk;
    logic [95:0] k;
    nR = 0; key_valid = 0; key_in = '0; mode_in = 0; in_valid = 0; in_data = '0; out_ready = 0;
    coreLatency = 1; coreHold = 0; coreStall = 0; curKey = '0; curMode = 0; blkExp = 0;
    repeat (3) @(negedge clk);
    checkZeroOutputs("rst");
    nR = 1;
    @(negedge clk);

    in_data = {$urandom, $urandom}; in_valid = 1;
    repeat (8) begin
      @(negedge clk);
      checkBit("nokey_in_ready", in_ready, 1'b0);
      checkBit("nokey_newData", newData, 1'b0);
    end
    in_valid = 0;

    coreHold = 2;
    applyKey(KEY_V, 1'b1);
    checkBit("enc_newKey", newKey, 1'b1);
    checkBit("enc_exclusive", newData, 1'b0);
    checkWord("enc_KEY", 128'(KEY), 128'(KEY_V));
    checkBit("enc_dir", enc_dec, 1'b1);
    waitIdle("enc_keyload");
    checkBit("enc_in_ready", in_ready, 1'b1);
    applyBlock(PT, 1'b1);
    checkBit("enc_newData", newData, 1'b1);
    checkBit("enc_newKey_low", newKey, 1'b0);
    checkWord("enc_blockIN", 128'(blockIN), 128'(PT));
    waitOutValid("enc_result");
    checkWord("enc_out_data", 128'(out_data), 128'(expQ.pop_front()));
    checkBit("enc_readData", readData, 1'b1);
    c = 0;
    while (doneData === 1'b1 && c < 50) begin @(negedge clk); c++; end
    checkBit("enc_ack_hold", readData, 1'b1);
    @(negedge clk);
    checkBit("enc_ack_release", readData, 1'b0);
    checkBit("enc_idle", busy, 1'b0);
    checkWord("enc_blk_count", 128'(blk_count), 128'(1));
    checkBit("enc_pending_in_ready", in_ready, 1'b0);
    checkBit("enc_result_held", out_valid, 1'b1);
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    checkBit("enc_drained", out_valid, 1'b0);
    checkBit("enc_ready_again", in_ready, 1'b1);
    blkExp = 1;

    coreHold = 0;
    applyKey(KEY_V, 1'b0);
    checkBit("dec_dir", enc_dec, 1'b0);
    waitIdle("dec_keyload");
    applyBlock(CT, 1'b1);
    drainResult("dec", 1);
    checkWord("dec_plain", 128'(out_data), 128'(PT));
    waitIdle("dec_done");
    checkWord("dec_blk_count", 128'(blk_count), 128'(blkExp));

    k = {$urandom, $urandom, $urandom};
    key_in = k; mode_in = 1; key_valid = 1; in_data = {$urandom, $urandom}; in_valid = 1;
    #1;
    checkBit("prio_in_ready", in_ready, 1'b0);
    checkBit("prio_key_ready", key_ready, 1'b1);
    @(negedge clk);
    key_valid = 0; in_valid = 0; curKey = k; curMode = 1;
    checkBit("prio_newKey", newKey, 1'b1);
    checkBit("prio_newData", newData, 1'b0);
    waitIdle("prio_done");

    nR = 0;
    @(negedge clk);
    nR = 1; blkExp = 0; expQ.delete();
    applyKey({$urandom, $urandom, $urandom}, 1'($urandom_range(0, 1)));
    waitIdle("b2b_keyload");
    nextBlk = {$urandom, $urandom};
    for (int i = 0; i < 5; i++) begin
      coreLatency = $urandom_range(0, 3);
      coreHold = $urandom_range(0, 2);
      applyBlock(nextBlk, 1'b1);
      if (i < 4) begin
        nextBlk = {$urandom, $urandom};
        waitOutValid("b2b_wait");
        in_data = nextBlk; in_valid = 1;
        blkExp--;
      end
      drainResult("b2b", $urandom_range(1, 4));
    end
    blkExp += 4;
    waitIdle("b2b_done");
    checkWord("b2b_blk_count", 128'(blk_count), 128'(blkExp));
    checkBit("b2b_none_lost", expQ.size() == 0, 1'b1);

    coreStall = 1;
    applyBlock({$urandom, $urandom}, 1'b0);
    c = 0;
    while (newData === 1'b1 && c < 40) begin c++; @(negedge clk); end
    checkWord("wd_cycles", 128'(c), 128'(15));
    checkBit("wd_timeout", timeout, 1'b1);
    checkBit("wd_idle", busy, 1'b0);
    checkBit("wd_newData", newData, 1'b0);
    coreStall = 0;
    repeat (5) @(negedge clk);
    checkBit("wd_sticky", timeout, 1'b1);

    nR = 0;
    @(negedge clk);
    nR = 1;
    checkBit("rst_clears_timeout", timeout, 1'b0);
    coreLatency = 8; coreHold = 0;
    applyKey(KEY_V, 1'b1);
    waitIdle("midrst_keyload");
    applyBlock(PT, 1'b0);
    c = 0;
    while (newData === 1'b1 && c < 20) begin @(negedge clk); c++; end
    checkBit("midrst_in_busy", busy, 1'b1);
    @(negedge clk);
    nR = 0;
    @(negedge clk);
    checkZeroOutputs("midrst");
    nR = 1;
    repeat (3) @(negedge clk);
    checkBit("midrst_needs_key", in_ready, 1'b0);
    checkBit("midrst_no_result", out_valid, 1'b0);
    coreLatency = 1; blkExp = 0;
    applyKey(KEY_V, 1'b1);
    waitIdle("midrst_reload");
    checkBit("midrst_reload_in_ready", in_ready, 1'b1);
    applyBlock(PT, 1'b1);
    drainResult("midrst_post", 0);
    waitIdle("midrst_post_idle");
    checkWord("midrst_blk_count", 128'(blk_count), 128'(blkExp));

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
